// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 frame loader: frame geometry, loader states
// and the byte-lane sequencing helper.
package hub75_pkg;

  localparam int FB_WORDS       = 2048;
  localparam int BYTES_PER_WORD = 3;
  localparam int BYTE_IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  // Lane that the next accepted byte fills; wraps after the third byte of a word.
  function automatic logic [BYTE_IDX_W-1:0] next_byte_idx(input logic [BYTE_IDX_W-1:0] idx);
    logic [BYTE_IDX_W-1:0] last;
    last = BYTE_IDX_W'(BYTES_PER_WORD - 1);
    if (idx == last) begin
      return '0;
    end
    return idx + BYTE_IDX_W'(1);
  endfunction

endpackage

// File: rtl/hub75_fb_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// The address MSB selects the bank; no reset so it maps onto block RAM.
module hub75_fb_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hub75_frame_loader.sv
// Streams bytes into the back bank of a double-buffered frame store and swaps
// banks only on a display frame boundary.
module hub75_frame_loader
  import hub75_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_sof,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  frame_end,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  bank_sel,
  output logic                  swap_pending,
  output logic                  frame_done,
  output logic                  sync_err,
  output logic [7:0]            frame_count
);

  state_t                r_state;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_we;
  logic [15:0]           r_word;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_bank_sel;
  logic                  r_swap_pending;
  logic                  r_frame_done;
  logic                  r_sync_err;
  logic [7:0]            r_frame_count;
  logic                  r_rd_valid;

  logic                  w_accept;
  logic                  w_last_write;
  logic                  w_load_byte;
  logic                  w_resync;
  logic                  w_stray;
  logic [BYTE_IDX_W-1:0] w_pos;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign s_ready      = (r_state != WAIT_SWAP);
  assign w_accept     = s_valid & s_ready;
  assign w_last_write = r_we & (&r_waddr);

  // The cycle that commits the final word closes the frame; a byte accepted
  // in that same cycle has no frame to join and is discarded.
  assign w_load_byte  = w_accept &
                        (((r_state == IDLE) & s_sof) |
                         ((r_state == LOAD) & ~w_last_write));
  assign w_pos        = s_sof ? '0 : r_byte_idx;
  assign w_resync     = w_load_byte & s_sof & (r_state == LOAD);
  assign w_stray      = w_accept & (r_state == IDLE) & ~s_sof;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_byte_idx     <= '0;
      r_waddr        <= '0;
      r_we           <= 1'b0;
      r_bank_sel     <= 1'b0;
      r_swap_pending <= 1'b0;
      r_frame_done   <= 1'b0;
      r_sync_err     <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_we         <= w_load_byte && (w_pos == BYTE_IDX_W'(BYTES_PER_WORD - 1));
      r_frame_done <= 1'b0;
      r_sync_err   <= w_stray | w_resync;

      if (r_we) begin
        r_waddr <= r_waddr + ADDR_WIDTH'(1);
      end
      // A start-of-frame byte restarts at word 0 even if a write is in flight.
      if (w_load_byte) begin
        r_byte_idx <= next_byte_idx(w_pos);
        if (s_sof) begin
          r_waddr <= '0;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_load_byte) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_last_write) begin
            r_state        <= WAIT_SWAP;
            r_swap_pending <= 1'b1;
            r_byte_idx     <= '0;
          end
        end
        WAIT_SWAP: begin
          if (frame_end) begin
            r_state        <= IDLE;
            r_bank_sel     <= ~r_bank_sel;
            r_swap_pending <= 1'b0;
            r_frame_done   <= 1'b1;
            r_frame_count  <= r_frame_count + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_byte) begin
      case (w_pos)
        2'd0:    r_word[7:0]  <= s_data;
        2'd1:    r_word[15:8] <= s_data;
        default: r_wdata      <= {s_data, r_word};
      endcase
    end
  end

  // Gates the unreset RAM output so rd_data reads zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b1;
    end
  end

  hub75_fb_ram #(
    .ADDR_WIDTH(ADDR_WIDTH + 1),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fb_ram (
    .clk     (clk),
    .i_we    (r_we),
    .i_waddr ({~r_bank_sel, r_waddr}),
    .i_wdata (r_wdata),
    .i_raddr ({r_bank_sel, rd_addr}),
    .o_rdata (w_ram_q)
  );

  assign rd_data      = r_rd_valid ? w_ram_q : '0;
  assign bank_sel     = r_bank_sel;
  assign swap_pending = r_swap_pending;
  assign frame_done   = r_frame_done;
  assign sync_err     = r_sync_err;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_hub75_frame_loader.sv
// Directed bench for hub75_frame_loader with a byte-counting reference model.
module tb_hub75_frame_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;
  logic        frame_end;
  logic [10:0] rd_addr;
  logic [23:0] rd_data;
  logic        bank_sel;
  logic        swap_pending;
  logic        frame_done;
  logic        sync_err;
  logic [7:0]  frame_count;

  hub75_frame_loader #(.ADDR_WIDTH(11), .DATA_WIDTH(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .frame_end    (frame_end),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .bank_sel     (bank_sel),
    .swap_pending (swap_pending),
    .frame_done   (frame_done),
    .sync_err     (sync_err),
    .frame_count  (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  int hs = 0, errp = 0, donep = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame progress tracked as a count of bytes in the frame.
  logic [23:0] m_mem [2][2048];
  bit          m_known [2][2048];
  int          m_st;     // 0 idle, 1 loading, 2 waiting for frame_end
  int          m_nb;
  bit          m_fin, m_bank, m_pend, m_done, m_err, m_rd_ok, m_acc;
  int          m_cnt;
  logic [23:0] m_cur, m_rd;

  initial begin
    m_st = 0; m_nb = 0; m_fin = 0; m_bank = 0; m_pend = 0; m_done = 0;
    m_err = 0; m_cnt = 0; m_rd = 0; m_rd_ok = 1; m_cur = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_st = 0; m_nb = 0; m_fin = 0; m_bank = 0; m_pend = 0;
        m_done = 0; m_err = 0; m_cnt = 0; m_rd = 0; m_rd_ok = 1;
      end else begin
        m_rd_ok = m_known[int'(m_bank)][rd_addr];
        m_rd    = m_mem[int'(m_bank)][rd_addr];
        m_acc   = s_valid && (m_st != 2);
        m_done  = 0;
        m_err   = 0;
        if (m_st == 2) begin
          if (frame_end) begin
            m_bank = !m_bank; m_pend = 0; m_done = 1;
            m_cnt = (m_cnt + 1) % 256; m_st = 0;
          end
        end else if (m_fin) begin
          m_fin = 0; m_pend = 1; m_st = 2;
        end else if (m_acc) begin
          if (m_st == 0 && !s_sof) begin
            m_err = 1;
          end else begin
            if (s_sof) begin
              if (m_st == 1) m_err = 1;
              m_nb = 0;
              m_st = 1;
            end
            m_cur[(m_nb % 3) * 8 +: 8] = s_data;
            if (m_nb % 3 == 2) begin
              m_mem[int'(!m_bank)][m_nb / 3]   = m_cur;
              m_known[int'(!m_bank)][m_nb / 3] = 1;
              if (m_nb / 3 == 2047) m_fin = 1;
            end
            m_nb++;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("s_ready", s_ready, (m_st != 2));
      check("bank_sel", bank_sel, m_bank);
      check("swap_pending", swap_pending, m_pend);
      check("frame_done", frame_done, m_done);
      check("sync_err", sync_err, m_err);
      check("frame_count", frame_count, m_cnt[7:0]);
      if (m_rd_ok) check("rd_data", rd_data, m_rd);
      if (s_valid && s_ready) hs++;
      if (sync_err) errp++;
      if (frame_done) donep++;
    end
  end

  task automatic send(input logic [7:0] d, input logic sof);
    int   n;
    logic rdy;
    s_data = d; s_sof = sof; s_valid = 1'b1;
    n = 0; rdy = 1'b0;
    while (!rdy && n < 1000) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) check("send_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] pat_a(input int k);
    int n;
    n = k / 3;
    case (k % 3)
      0:       return 8'hC3;
      1:       return 8'h5A;
      default: return n[7:0];
    endcase
  endfunction

  function automatic logic [7:0] pat_b(input int k);
    if (k == 0) return 8'h11;
    return k[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] pat_c(input int k);
    return k[7:0] + 8'h10;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int hs0;

  initial begin
    rst = 1'b0; s_valid = 0; s_sof = 0; s_data = 0; frame_end = 0; rd_addr = 0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    check("rst_ready", s_ready, 1);
    check("rst_bank", bank_sel, 0);
    check("rst_count", frame_count, 0);
    check("rst_pending", swap_pending, 0);
    check("rst_rd", rd_data, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Stray byte in IDLE
    @(posedge clk); #1 s_valid = 1; s_sof = 0; s_data = 8'hFF;
    @(posedge clk); #1 s_valid = 0;
    check("stray_err", sync_err, 1);
    check("stray_ready", s_ready, 1);

    // Frame A with frame_end pulses during LOAD
    for (int k = 0; k < 6144; k++) begin
      frame_end = (k == 3000 || k == 4500);
      rd_addr = 11'(k);
      send(pat_a(k), k == 0);
    end
    s_valid = 0; frame_end = 0;
    @(posedge clk); #1;
    check("a_pending", swap_pending, 1);
    check("a_ready", s_ready, 0);
    check("a_bank_hold", bank_sel, 0);
    frame_end = 1;
    @(posedge clk); #1 frame_end = 0;
    check("a_bank", bank_sel, 1);
    check("a_done", frame_done, 1);
    check("a_count", frame_count, 1);
    rd_addr = 11'd3;
    @(posedge clk); #1;
    check("a_word3", rd_data, 24'h035AC3);
    rd_addr = 11'd2047;
    @(posedge clk); #1;
    check("a_word2047", rd_data, 24'hFF5AC3);

    // Frame B: partial then resync, last write coincides with frame_end
    for (int k = 0; k < 100; k++) send(8'hEE, k == 0);
    for (int k = 0; k < 6144; k++) begin
      rd_addr = 11'(k * 7);
      send(pat_b(k), k == 0);
    end
    s_valid = 0; frame_end = 1;
    @(posedge clk); #1 frame_end = 0;
    check("b_coincide_bank", bank_sel, 1);
    check("b_coincide_pend", swap_pending, 1);
    check("b_done_count", donep, 1);
    check("b_err_count", errp, 2);

    // Backpressure while waiting for the swap
    hs0 = hs;
    s_valid = 1; s_sof = 1; s_data = 8'h77;
    repeat (500) @(posedge clk);
    #1;
    check("bp_accepts", hs - hs0, 0);
    check("bp_bank", bank_sel, 1);
    frame_end = 1;
    @(posedge clk); #1 frame_end = 0;
    send(8'h77, 1);
    check("b_bank", bank_sel, 0);
    check("b_count", frame_count, 2);

    // Frame C resumes after the swap
    for (int k = 1; k < 6144; k++) begin
      rd_addr = 11'(k * 5);
      send(pat_c(k), 0);
    end
    s_valid = 0;
    @(posedge clk); #1;
    check("c_pending", swap_pending, 1);
    rd_addr = 11'd0;
    @(posedge clk); #1;
    check("b_word0", rd_data, 24'h3E3D11);
    rd_addr = 11'd2047;
    @(posedge clk); #1;
    check("b_word2047", rd_data, 24'hC3C2C1);
    frame_end = 1;
    @(posedge clk); #1 frame_end = 0;
    check("c_bank", bank_sel, 1);
    check("c_count", frame_count, 3);

    // Reset in the middle of frame D
    for (int k = 0; k < 10; k++) send(8'hA0 + 8'(k), k == 0);
    s_valid = 0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_bank", bank_sel, 0);
    check("mid_rst_count", frame_count, 0);
    check("mid_rst_pending", swap_pending, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_rst_rd", rd_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("end_done_count", donep, 3);
    check("end_err_count", errp, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
